// File: rtl/cuppa_wvb_acq_ctrl.sv
// CUPPA waveform-buffer acquisition FSM: circular-buffer writer (1-cycle write latency), trigger detect, event handoff.
// Descriptor held in DONE until evt_valid && evt_ready; optional trigger counter under `CUPPA_WVB_TRIG_CNT_EN.
module cuppa_wvb_acq_ctrl #(
    parameter int P_ADC_BITS  = 14,
    parameter int P_ADDR_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [53:0]            wvb_conf_bundle,
    input  logic [P_ADC_BITS-1:0]  adc_data,
    input  logic                   ext_trig,
    output logic                   wr_en,
    output logic [P_ADDR_BITS-1:0] wr_addr,
    output logic [P_ADC_BITS-1:0]  wr_data,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [P_ADDR_BITS-1:0] evt_start,
    output logic [15:0]            evt_len,
    output logic                   armed,
    output logic                   conf_err,
    output logic [15:0]            trig_count
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [15:0] DEPTH_M1 = 16'((1 << P_ADDR_BITS) - 1);

    logic [14:0] cf_cnst, cf_test, cf_post;
    logic [5:0]  cf_pre;
    logic        cf_arm, cf_mode, cf_run;

    assign cf_cnst = wvb_conf_bundle[14:0];
    assign cf_test = wvb_conf_bundle[29:15];
    assign cf_post = wvb_conf_bundle[44:30];
    assign cf_pre  = wvb_conf_bundle[50:45];
    assign cf_arm  = wvb_conf_bundle[51];
    assign cf_mode = wvb_conf_bundle[52];
    assign cf_run  = wvb_conf_bundle[53];

    state_t                 state_q;
    logic                   wr_en_q, evt_valid_q, armed_q, conf_err_q;
    logic [P_ADDR_BITS-1:0] wr_addr_q, wr_ptr_q, wr_ptr_d, evt_start_q;
    logic [P_ADC_BITS-1:0]  wr_data_q, adc_prev_q;
    logic [15:0]            evt_len_q, post_q, post_cnt_q;
    logic [5:0]             pre_q, pre_cnt_q;
    logic [14:0]            test_q, cnst_q, armed_cnt_q;
    logic                   run_q, ext_prev_q;

    // Post length is clamped so one event never exceeds the buffer depth.
    logic [15:0] post_lim, post_eff;
    logic        post_clamp;
    assign post_lim   = DEPTH_M1 - 16'(cf_pre);
    assign post_clamp = 16'(cf_post) > post_lim;
    assign post_eff   = post_clamp ? post_lim : 16'(cf_post);

    logic [14:0] adc_ext, adc_prev_ext, cnst_eff;
    logic        trig_ext, trig_thr, trig_cnst, trig_hit, trig_acc;
    assign adc_ext      = 15'(adc_data);
    assign adc_prev_ext = 15'(adc_prev_q);
    assign cnst_eff     = (cnst_q == 15'd0) ? 15'd1 : cnst_q;
    assign trig_ext     = ext_trig & ~ext_prev_q;
    assign trig_thr     = (adc_prev_ext < test_q) && (adc_ext >= test_q);
    assign trig_cnst    = run_q && (armed_cnt_q == cnst_eff);
    assign trig_hit     = (cf_mode ? trig_thr : trig_ext) | trig_cnst;
    assign trig_acc     = (state_q == S_ARMED) && cf_arm && trig_hit;

    logic snap, do_wr;
    assign snap  = cf_arm && ((state_q == S_IDLE) ||
                              ((state_q == S_DONE) && evt_valid_q && evt_ready));
    assign do_wr = cf_arm && ((state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST));
    assign wr_ptr_d = wr_ptr_q + P_ADDR_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            post_q     <= '0;
            test_q     <= '0;
            cnst_q     <= '0;
            run_q      <= 1'b0;
            conf_err_q <= 1'b0;
        end else if (snap) begin
            pre_q      <= cf_pre;
            post_q     <= post_eff;
            test_q     <= cf_test;
            cnst_q     <= cf_cnst;
            run_q      <= cf_run;
            conf_err_q <= post_clamp;
        end
    end

    // Trigger history registers track every cycle so edges are seen on ARMED entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ptr_q   <= '0;
            ext_prev_q <= 1'b0;
            adc_prev_q <= '0;
        end else begin
            ext_prev_q <= ext_trig;
            adc_prev_q <= adc_data;
            wr_en_q    <= do_wr;
            if (do_wr) begin
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= adc_data;
                wr_ptr_q  <= wr_ptr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_start_q <= '0;
            evt_len_q   <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            armed_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (snap) begin
                        state_q     <= (cf_pre == 6'd0) ? S_ARMED : S_PRE;
                        armed_q     <= 1'b1;
                        pre_cnt_q   <= cf_pre - 6'd1;
                        armed_cnt_q <= 15'd1;
                    end
                end
                S_PRE: begin
                    if (!cf_arm) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (pre_cnt_q == 6'd0) begin
                        state_q     <= S_ARMED;
                        armed_cnt_q <= 15'd1;
                    end else begin
                        pre_cnt_q <= pre_cnt_q - 6'd1;
                    end
                end
                S_ARMED: begin
                    if (!cf_arm) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (trig_acc) begin
                        evt_start_q <= wr_ptr_q - P_ADDR_BITS'(pre_q);
                        evt_len_q   <= 16'(pre_q) + 16'd1 + post_q;
                        post_cnt_q  <= post_q - 16'd1;
                        if (post_q == 16'd0) begin
                            state_q <= S_DONE;
                            armed_q <= 1'b0;
                        end else begin
                            state_q <= S_POST;
                        end
                    end else begin
                        armed_cnt_q <= armed_cnt_q + 15'd1;
                    end
                end
                S_POST: begin
                    if (!cf_arm) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (post_cnt_q == 16'd0) begin
                        state_q <= S_DONE;
                        armed_q <= 1'b0;
                    end else begin
                        post_cnt_q <= post_cnt_q - 16'd1;
                    end
                end
                S_DONE: begin
                    // First DONE cycle only raises valid, so it trails the last write strobe.
                    if (!evt_valid_q) begin
                        evt_valid_q <= 1'b1;
                    end else if (evt_ready) begin
                        evt_valid_q <= 1'b0;
                        if (snap) begin
                            state_q     <= (cf_pre == 6'd0) ? S_ARMED : S_PRE;
                            armed_q     <= 1'b1;
                            pre_cnt_q   <= cf_pre - 6'd1;
                            armed_cnt_q <= 15'd1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CUPPA_WVB_TRIG_CNT_EN
    logic [15:0] trig_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt_q <= '0;
        end else if (trig_acc && (trig_cnt_q != 16'hFFFF)) begin
            trig_cnt_q <= trig_cnt_q + 16'd1;
        end
    end
    assign trig_count = trig_cnt_q;
`else
    assign trig_count = 16'd0;
`endif

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign evt_valid = evt_valid_q;
    assign evt_start = evt_start_q;
    assign evt_len   = evt_len_q;
    assign armed     = armed_q;
    assign conf_err  = conf_err_q;

endmodule
